// File: rtl/avr_asm_encoder.sv
// Streaming AVR instruction encoder: one structured request in, one or two program words out.
// Optional operand range checking is enabled by defining AVR_ASM_RANGE_CHK_EN.
module avr_asm_encoder #(
  parameter int unsigned       ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] RST_ADR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adr_ld,
  input  logic [ADDR_W-1:0] adr_val,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [5:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rr,
  input  logic [21:0]       req_k,
  input  logic [2:0]        req_b,
  output logic              pmw_vld,
  input  logic              pmw_rdy,
  output logic [ADDR_W-1:0] pmw_adr,
  output logic [15:0]       pmw_dat,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StWord0, StWord1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [15:0]       dat_q, dat_d;
  logic [15:0]       w1_q, w1_d;
  logic              vld_q, vld_d;
  logic              two_q, two_d;
  logic              err_q, err_d;

  logic [15:0] enc_w0;
  logic        enc_two;
  logic        op_legal;
  logic        accept_ok;

  always_comb begin
    enc_w0   = '0;
    enc_two  = 1'b0;
    op_legal = 1'b1;
    case (req_op) inside
      6'd0:          enc_w0 = 16'h0000;
      6'd1:          enc_w0 = {8'h01, req_rd[4:1], req_rr[4:1]};
      [6'd2:6'd12]:  enc_w0 = {2'b00, 4'(req_op - 6'd1), req_rr[4], req_rd, req_rr[3:0]};
      [6'd13:6'd18]: enc_w0 = {(req_op == 6'd18) ? 4'hE : 4'(req_op - 6'd10),
                               req_k[7:4], req_rd[3:0], req_k[3:0]};
      6'd19, 6'd20:  enc_w0 = {4'b1011, req_op == 6'd20, req_k[5:4], req_rd, req_k[3:0]};
      6'd21, 6'd22:  enc_w0 = {3'b110, req_op == 6'd22, req_k[11:0]};
      6'd23, 6'd24:  enc_w0 = {5'b11110, req_op == 6'd24, req_k[6:0], req_b};
      6'd25, 6'd26: begin
        enc_w0  = {7'b1001010, req_k[21:17], 2'b11, req_op == 6'd26, req_k[16]};
        enc_two = 1'b1;
      end
      6'd27, 6'd28: begin
        enc_w0  = {6'b100100, req_op == 6'd28, req_rd, 4'h0};
        enc_two = 1'b1;
      end
      6'd29, 6'd30:  enc_w0 = {6'b100100, req_op == 6'd29, req_rd, 4'hF};
      6'd31:         enc_w0 = 16'h9508;
      6'd32:         enc_w0 = 16'h9518;
      default:       op_legal = 1'b0;
    endcase
  end

`ifdef AVR_ASM_RANGE_CHK_EN
  logic range_bad;

  // Signed offsets fit when all bits above the field are a sign extension.
  always_comb begin
    range_bad = 1'b0;
    case (req_op) inside
      6'd1:          range_bad = req_rd[0] | req_rr[0];
      [6'd13:6'd18]: range_bad = ~req_rd[4] | (|req_k[21:8]);
      6'd19, 6'd20:  range_bad = |req_k[21:6];
      6'd21, 6'd22:  range_bad = ~((&req_k[21:11]) | ~(|req_k[21:11]));
      6'd23, 6'd24:  range_bad = ~((&req_k[21:6]) | ~(|req_k[21:6]));
      6'd27, 6'd28:  range_bad = |req_k[21:16];
      default:       range_bad = 1'b0;
    endcase
  end

  assign accept_ok = op_legal & ~range_bad;
`else
  assign accept_ok = op_legal;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    w1_d    = w1_q;
    vld_d   = vld_q;
    two_d   = two_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (adr_ld) begin
          cnt_d = adr_val;
        end else if (req_vld) begin
          if (accept_ok) begin
            state_d = StWord0;
            vld_d   = 1'b1;
            dat_d   = enc_w0;
            adr_d   = cnt_q;
            w1_d    = req_k[15:0];
            two_d   = enc_two;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWord0: begin
        if (pmw_rdy) begin
          cnt_d = cnt_q + 1'b1;
          if (two_q) begin
            state_d = StWord1;
            dat_d   = w1_q;
            adr_d   = cnt_q + 1'b1;
          end else begin
            state_d = StIdle;
            vld_d   = 1'b0;
          end
        end
      end
      StWord1: begin
        if (pmw_rdy) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StIdle;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= RST_ADR;
      adr_q   <= RST_ADR;
      dat_q   <= '0;
      w1_q    <= '0;
      vld_q   <= 1'b0;
      two_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      w1_q    <= w1_d;
      vld_q   <= vld_d;
      two_q   <= two_d;
      err_q   <= err_d;
    end
  end

  assign req_rdy = (state_q == StIdle) & ~adr_ld;
  assign busy    = (state_q != StIdle);
  assign pmw_vld = vld_q;
  assign pmw_adr = adr_q;
  assign pmw_dat = dat_q;
  assign err     = err_q;

endmodule

// File: doc/avr_asm_encoder.md
Name: avr_asm_encoder

Overview:
- Streaming instruction encoder; the inverse of the disassembler. Takes one structured request per handshake: opcode enum, register, constant and bit-index fields.
- Emits the AVR 16-bit machine word(s) into a program-memory write port at an auto-incrementing word address.
- Used by benches and the boot/loader path to build program images in place, with no precompiled hex.

Parameters:
- ADDR_W, 16, width of program-memory word address.
- RST_ADR, 0, address counter value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- adr_ld  in  1  load the address counter from adr_val.
- adr_val  in  ADDR_W  new address value.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_op  in  6  opcode enum (see Behaviour).
- req_rd  in  5  destination register Rd.
- req_rr  in  5  source register Rr.
- req_k  in  22  constant, I/O address, absolute address or signed relative offset.
- req_b  in  3  SREG bit index.
- pmw_vld  out  1  write word valid.
- pmw_rdy  in  1  write word accepted.
- pmw_adr  out  ADDR_W  word address.
- pmw_dat  out  16  instruction word.
- err  out  1  one-cycle pulse: request rejected.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: state=IDLE, address counter=RST_ADR, pmw_vld=0, pmw_dat=0, pmw_adr=RST_ADR, err=0, busy=0. req_rdy is combinational and therefore 1 after reset.
- States and transitions:
  - IDLE: req_rdy = !adr_ld. If adr_ld is high, the counter is loaded from adr_val and no request is accepted that cycle (adr_ld has priority).
  - Request accepted at edge N (req_vld & req_rdy), legal opcode: goes to WORD0 and presents pmw_vld=1, pmw_dat=word0, pmw_adr=counter at N+1.
  - Request accepted at edge N, illegal opcode: err=1 at N+1, stays IDLE, no write, counter unchanged.
  - WORD0: holds pmw_* stable until pmw_rdy. On acceptance the counter increments. A two-word op goes to WORD1 (second word at counter+1, next cycle); otherwise goes to IDLE.
  - WORD1: same hold rule. On acceptance the counter increments and the state goes to IDLE.
  - adr_ld is ignored outside IDLE.
- Throughput: one-word op takes 2 cycles minimum; two-word op takes 3 cycles minimum. req_rdy is low in WORD0 and WORD1.
- Address counter wraps modulo 2^ADDR_W, including between word0 and word1.
- Opcode enum and encoding (K=req_k, d=req_rd, r=req_rr):
  - 0 NOP: 0x0000.
  - 1 MOVW: 0x01 with d[4:1], r[4:1].
  - 2..12 CPC, SBC, ADD, CPSE, CP, SUB, ADC, AND, EOR, OR, MOV: {2'b00, op-1 (4 bits), r[4], d, r[3:0]}.
  - 13..18 CPI, SBCI, SUBI, ORI, ANDI, LDI: {hi, K[7:4], d[3:0], K[3:0]}, with hi = 3, 4, 5, 6, 7, E respectively.
  - 19 IN: {5'b10110, K[5:4], d, K[3:0]}.
  - 20 OUT: same as IN with bit 11 = 1.
  - 21 RJMP: {4'hC, K[11:0]}.
  - 22 RCALL: {4'hD, K[11:0]}.
  - 23 BRBS: {6'b111100, K[6:0], b}.
  - 24 BRBC: same as BRBS with bit 10 = 1.
  - 25 JMP: {7'b1001010, K[21:17], 3'b110, K[16]}, then second word K[15:0].
  - 26 CALL: as JMP with 3'b111, then K[15:0].
  - 27 LDS: {7'b1001000, d, 4'h0}, then K[15:0].
  - 28 STS: {7'b1001001, d, 4'h0}, then K[15:0].
  - 29 PUSH: {7'b1001001, d, 4'hF}.
  - 30 POP: {7'b1001000, d, 4'hF}.
  - 31 RET: 0x9508.
  - 32 RETI: 0x9518.
  - 33..63: illegal, always err.
- Two-word ops: 25..28.
- Unused request fields are ignored.
- Reset asserted mid-operation (WORD0/WORD1): the partial write is abandoned. pmw_vld drops asynchronously, and the counter returns to RST_ADR.

Optional Feature:
- Macro: AVR_ASM_RANGE_CHK_EN.
- Defined: operand range violations are illegal (err pulse, no write):
  - MOVW with d or r odd.
  - Ops 13..18 with d<16 or K>255.
  - IN/OUT with K>63.
  - RJMP/RCALL with K (22-bit signed) outside -2048..2047.
  - BRBS/BRBC with K outside -64..63.
  - LDS/STS with K>0xFFFF.
- Not defined: fields are silently truncated as per the encodings; err only for opcodes 33..63.

Test Plan:
- ADD r1,r2 (op=4, d=1, r=2) after reset -> pmw_dat=0x0C12, pmw_adr=0x0000 at N+1; next request is accepted at address 0x0001.
- adr_ld with adr_val=0x0100, then LDI r16,0xAB (op=18) -> pmw_dat=0xEA0B at pmw_adr=0x0100.
- JMP K=0x000123 with pmw_rdy held low 3 cycles -> 0x940C at A held stable, then 0x0123 at A+1; req_rdy=0 throughout. With ADDR_W=4 and A=0xF, the second word goes to 0x0.
- RJMP K=-1 -> 0xCFFF; BRBS b=1 K=-2 -> 0xF3F1.
- With AVR_ASM_RANGE_CHK_EN defined: LDI r15 -> err=1 for exactly one cycle, no pmw_vld, counter unchanged. Op=40 -> err regardless of the macro.
- rst_n asserted while in WORD1 of CALL -> pmw_vld=0 immediately, busy=0, pmw_adr=RST_ADR after release.
